// File: rtl/texture_mapper_div_pkg.sv
// Shared types and constants for the texture-mapper divider arbiter.
// Optional feature macro: TEXTURE_MAPPER_DIV_DBZ_EN adds a divide-by-zero flag to each tag.
package texture_mapper_div_pkg;

    // The id field is sized for the largest supported requester count (8).
    localparam int REQ_ID_W            = 3;
    localparam int DEFAULT_DIV_LATENCY = 32;

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
        logic                dbz;
`endif
    } tag_t;

endpackage

// File: rtl/texture_mapper_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i.
module texture_mapper_rr_arbiter
    import texture_mapper_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = REQ_ID_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    int   j_s;
    logic found_s;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        j_s         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j_s = int'(ptr_i) + k;
            if (j_s >= NUM_REQ) begin
                j_s = j_s - NUM_REQ;
            end else begin
                j_s = j_s;
            end
            if (en_i && !found_s && req_i[j_s]) begin
                found_s        = 1'b1;
                grant_o[j_s]   = 1'b1;
                grant_idx_o    = ID_W'(j_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/texture_mapper_div_arbiter.sv
// Shares one external pipelined divider among NUM_REQ requesters.
// A tag shift register tracks the divider pipeline and steers results back.
// Optional feature macro: TEXTURE_MAPPER_DIV_DBZ_EN (adds rsp_dbz output).
module texture_mapper_div_arbiter
    import texture_mapper_div_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH_N     = 32,
    parameter int WIDTH_D     = 32,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
    input  logic                              clock,
    input  logic                              aclr_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*WIDTH_N-1:0]        req_numer,
    input  logic [NUM_REQ*WIDTH_D-1:0]        req_denom,
    output logic [NUM_REQ-1:0]                rsp_valid,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic [WIDTH_N-1:0]                rsp_quotient,
    output logic [WIDTH_D-1:0]                rsp_remain,
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
    output logic                              rsp_dbz,
`endif
    output logic                              div_clken,
    output logic [WIDTH_N-1:0]                div_numer,
    output logic [WIDTH_D-1:0]                div_denom,
    input  logic [WIDTH_N-1:0]                div_quotient,
    input  logic [WIDTH_D-1:0]                div_remain,
    output logic [$clog2(DIV_LATENCY+1)-1:0]  in_flight
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    tag_t                tag_q [DIV_LATENCY];
    tag_t                tag_d;
    tag_t                head_s;
    logic [REQ_ID_W-1:0] ptr_q;
    logic [REQ_ID_W-1:0] ptr_d;
    logic [REQ_ID_W-1:0] grant_idx_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [NUM_REQ-1:0]  head_sel_s;
    logic                grant_vld_s;
    logic                clken_s;
    logic                arb_en_s;
    logic [CNT_W-1:0]    in_flight_q;
    logic [CNT_W-1:0]    in_flight_d;

    assign head_s = tag_q[DIV_LATENCY-1];

    // Decode the head tag into a one-hot response-valid vector.
    always_comb begin
        head_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            head_sel_s[i] = head_s.valid & (head_s.id == REQ_ID_W'(i));
        end
    end

    // The whole pipeline freezes while the head result is not accepted.
    assign clken_s      = ~|(head_sel_s & ~rsp_ready);
    assign div_clken    = clken_s;
    assign rsp_valid    = head_sel_s;
    assign rsp_quotient = div_quotient;
    assign rsp_remain   = div_remain;
    assign in_flight    = in_flight_q;
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
    assign rsp_dbz      = head_s.dbz & head_s.valid;
`endif

    // No grants while stalled or while reset is held.
    assign arb_en_s    = clken_s & aclr_n;
    assign grant_vld_s = |grant_s;
    assign req_ready   = grant_s;

    texture_mapper_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .en_i        (arb_en_s),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Route the granted requester's operands to the divider; 0/1 when idle.
    always_comb begin
        div_numer = '0;
        div_denom = WIDTH_D'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                div_numer = req_numer[i*WIDTH_N +: WIDTH_N];
                div_denom = req_denom[i*WIDTH_D +: WIDTH_D];
            end else begin
                div_numer = div_numer;
            end
        end
    end

    // Next tag, pointer and in-flight count for a shifting edge.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = grant_vld_s;
        tag_d.id    = grant_idx_s;
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
        tag_d.dbz   = grant_vld_s & (div_denom == '0);
`endif
        if (!grant_vld_s) begin
            ptr_d = ptr_q;
        end else if (grant_idx_s == REQ_ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_s + REQ_ID_W'(1);
        end
        case ({grant_vld_s, head_s.valid})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Tag pipeline, pointer and counter advance only on clock-enabled edges.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < DIV_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            ptr_q       <= '0;
            in_flight_q <= '0;
        end else if (clken_s) begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            ptr_q       <= ptr_d;
            in_flight_q <= in_flight_d;
        end else begin
            ptr_q       <= ptr_q;
            in_flight_q <= in_flight_q;
        end
    end

endmodule

// File: tb/tb_texture_mapper_div_arbiter.sv
// Directed self-checking bench for texture_mapper_div_arbiter with a
// behavioural 32-stage clock-enabled divider model.
module tb_texture_mapper_div_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int DL = 32;

    logic            clock = 1'b0;
    logic            aclr_n;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*W-1:0] req_numer, req_denom;
    logic [W-1:0]    rsp_quotient, rsp_remain;
    logic            div_clken;
    logic [W-1:0]    div_numer, div_denom, div_quotient, div_remain;
    logic [5:0]      in_flight;
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
    logic            rsp_dbz;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    texture_mapper_div_arbiter #(.NUM_REQ(NR), .WIDTH_N(W), .WIDTH_D(W), .DIV_LATENCY(DL)) dut (
        .clock(clock), .aclr_n(aclr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_numer(req_numer), .req_denom(req_denom),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain),
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
        .rsp_dbz(rsp_dbz),
`endif
        .div_clken(div_clken), .div_numer(div_numer), .div_denom(div_denom),
        .div_quotient(div_quotient), .div_remain(div_remain),
        .in_flight(in_flight)
    );

    always #5 clock = ~clock;

    // Divider model: operands shift through DL stages on enabled edges.
    logic [W-1:0] pn [DL];
    logic [W-1:0] pd [DL];
    initial begin
        for (int i = 0; i < DL; i++) begin
            pn[i] = '0;
            pd[i] = '0;
        end
    end
    always @(posedge clock) begin
        if (div_clken) begin
            pn[0] <= div_numer;
            pd[0] <= div_denom;
            for (int i = 1; i < DL; i++) begin
                pn[i] <= pn[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign div_quotient = (pd[DL-1] == '0) ? '1 : pn[DL-1] / pd[DL-1];
    assign div_remain   = (pd[DL-1] == '0) ? pn[DL-1] : pn[DL-1] % pd[DL-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
        req_numer[i*W +: W] = n;
        req_denom[i*W +: W] = d;
    endtask

    task automatic do_reset();
        aclr_n = 1'b0;
        #3;
        aclr_n = 1'b1;
        tick();
    endtask

    // Advance until any response is valid; returns edges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        #2;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else pass_cnt++;
        total_cnt++; if (div_clken !== 1'b1) $display("FAIL reset_clken got %b exp 1", div_clken); else pass_cnt++;
        total_cnt++; if (in_flight !== 6'd0) $display("FAIL reset_in_flight got %0d exp 0", in_flight); else pass_cnt++;
        aclr_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        set_op(2, 32'd100, 32'd7);
        req_valid = 4'b0100;
        #1;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL single_grant got %b exp 0100", req_ready); else pass_cnt++;
        total_cnt++; if (div_numer !== 32'd100 || div_denom !== 32'd7) $display("FAIL single_operands got %0d/%0d exp 100/7", div_numer, div_denom); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (in_flight !== 6'd1) $display("FAIL single_in_flight_up got %0d exp 1", in_flight); else pass_cnt++;
        total_cnt++; if (div_numer !== 32'd0 || div_denom !== 32'd1) $display("FAIL idle_operands got %0d/%0d exp 0/1", div_numer, div_denom); else pass_cnt++;
        wait_rsp(n);
        total_cnt++; if (n !== 31) $display("FAIL single_latency got %0d exp 31", n); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_quotient !== 32'd14 || rsp_remain !== 32'd2) $display("FAIL single_result got %0d r %0d exp 14 r 2", rsp_quotient, rsp_remain); else pass_cnt++;
        tick();
        total_cnt++; if (in_flight !== 6'd0 || rsp_valid !== 4'b0000) $display("FAIL single_drain got %0d/%b exp 0/0000", in_flight, rsp_valid); else pass_cnt++;
    endtask

    task automatic test_contention();
        int n;
        logic [W-1:0] eq [4] = '{32'd33, 32'd27, 32'd24, 32'd22};
        logic [W-1:0] er [4] = '{32'd1, 32'd3, 32'd2, 32'd1};
        logic [NR-1:0] oh;
        do_reset();
        set_op(0, 32'd100, 32'd3);
        set_op(1, 32'd111, 32'd4);
        set_op(2, 32'd122, 32'd5);
        set_op(3, 32'd133, 32'd6);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            oh = 4'b0001 << (k % 4);
            total_cnt++; if (req_ready !== oh) $display("FAIL contention_grant%0d got %b exp %b", k, req_ready, oh); else pass_cnt++;
            tick();
        end
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (in_flight !== 6'd8) $display("FAIL contention_in_flight got %0d exp 8", in_flight); else pass_cnt++;
        wait_rsp(n);
        for (int k = 0; k < 8; k++) begin
            oh = 4'b0001 << (k % 4);
            total_cnt++;
            if (rsp_valid !== oh || rsp_quotient !== eq[k%4] || rsp_remain !== er[k%4])
                $display("FAIL contention_rsp%0d got %b %0d r %0d exp %b %0d r %0d", k, rsp_valid, rsp_quotient, rsp_remain, oh, eq[k%4], er[k%4]);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (in_flight !== 6'd0) $display("FAIL contention_drain got %0d exp 0", in_flight); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        set_op(1, 32'd50, 32'd5);
        set_op(0, 32'd9, 32'd2);
        set_op(3, 32'd77, 32'd7);
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_rsp(n);
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (rsp_valid !== 4'b0010 || div_clken !== 1'b0 || req_ready !== 4'b0000 || in_flight !== 6'd2)
                $display("FAIL stall%0d got v=%b clken=%b rdy=%b inf=%0d exp v=0010 clken=0 rdy=0000 inf=2", k, rsp_valid, div_clken, req_ready, in_flight);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (rsp_quotient !== 32'd10 || rsp_remain !== 32'd0) $display("FAIL stall_result got %0d r %0d exp 10 r 0", rsp_quotient, rsp_remain); else pass_cnt++;
        rsp_ready = 4'b1111;
        #1;
        total_cnt++; if (div_clken !== 1'b1 || req_ready !== 4'b1000) $display("FAIL release got clken=%b rdy=%b exp 1 1000", div_clken, req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0001 || rsp_quotient !== 32'd4 || rsp_remain !== 32'd1 || in_flight !== 6'd2)
            $display("FAIL after_release got %b %0d r %0d inf=%0d exp 0001 4 r 1 inf=2", rsp_valid, rsp_quotient, rsp_remain, in_flight);
        else pass_cnt++;
        tick();
        wait_rsp(n);
        total_cnt++; if (rsp_valid !== 4'b1000 || rsp_quotient !== 32'd11) $display("FAIL retire_issue_rsp got %b %0d exp 1000 11", rsp_valid, rsp_quotient); else pass_cnt++;
        tick();
        total_cnt++; if (in_flight !== 6'd0 || rsp_valid !== 4'b0000) $display("FAIL bp_drain got %0d %b exp 0 0000", in_flight, rsp_valid); else pass_cnt++;
    endtask

    task automatic test_steady();
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 32'd1000 + 32'(i), 32'd10);
        req_valid = 4'b1111;
        for (int k = 0; k < 32; k++) tick();
        for (int k = 0; k < 6; k++) begin
            total_cnt++;
            if (in_flight !== 6'd32 || rsp_valid == 4'b0000 || req_ready == 4'b0000)
                $display("FAIL steady%0d got inf=%0d v=%b rdy=%b exp inf=32 with retire and issue", k, in_flight, rsp_valid, req_ready);
            else pass_cnt++;
            tick();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int stale;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) tick();
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (in_flight !== 6'd10) $display("FAIL mid_before got %0d exp 10", in_flight); else pass_cnt++;
        for (int k = 0; k < 20; k++) tick();
        #2;
        aclr_n = 1'b0;
        #1;
        total_cnt++; if (in_flight !== 6'd0 || rsp_valid !== 4'b0000) $display("FAIL mid_reset got %0d %b exp 0 0000", in_flight, rsp_valid); else pass_cnt++;
        aclr_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rsp_valid !== 4'b0000) stale++;
        end
        total_cnt++; if (stale !== 0) $display("FAIL mid_stale got %0d exp 0", stale); else pass_cnt++;
    endtask

`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
    task automatic test_dbz();
        int n;
        do_reset();
        set_op(0, 32'd5, 32'd0);
        set_op(1, 32'd5, 32'd1);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        wait_rsp(n);
        total_cnt++; if (rsp_valid !== 4'b0001 || rsp_dbz !== 1'b1) $display("FAIL dbz_set got %b %b exp 0001 1", rsp_valid, rsp_dbz); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 4'b0010 || rsp_dbz !== 1'b0 || rsp_quotient !== 32'd5) $display("FAIL dbz_clear got %b %b %0d exp 0010 0 5", rsp_valid, rsp_dbz, rsp_quotient); else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        aclr_n    = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_numer = '0;
        req_denom = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_steady();
        test_reset_mid();
`ifdef TEXTURE_MAPPER_DIV_DBZ_EN
        test_dbz();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
